// File: rtl/dcoef_collect_pkg.sv
// Shared definitions for the dcoef family: FSM state encoding and default
// frame geometry (bits per coefficient, coefficients per frame).
package dcoef_collect_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam int DCOEF_N = 4;
  localparam int DCOEF_K = 4;

endpackage

// File: rtl/dcoef_collect_if.sv
// Handshake and result bundle between a beat source and dcoef_collect.
interface dcoef_collect_if
  import dcoef_collect_pkg::*;
#(
  parameter int N = DCOEF_N,
  parameter int K = DCOEF_K
);

  logic         start;
  logic         din_valid;
  logic [K-1:0] dcoeff_in;
  logic [N-1:0] cdata0;
  logic [N-1:0] cdata1;
  logic [N-1:0] cdata2;
  logic [N-1:0] cdata3;
  logic         busy;
  logic         done;

  modport master (
    output start, din_valid, dcoeff_in,
    input  cdata0, cdata1, cdata2, cdata3, busy, done
  );

  modport slave (
    input  start, din_valid, dcoeff_in,
    output cdata0, cdata1, cdata2, cdata3, busy, done
  );

endinterface

// File: rtl/dcoef_collect_sipo.sv
// N-bit serial-in parallel-out register: LSB-first, new bits enter at the top.
// Clear has priority over shift.
module dcoef_sipo #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         shift_i,
  input  logic         bit_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (shift_i) begin
      q_d = (q_q >> 1) | (N'(bit_i) << (N - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/dcoef_collect.sv
// Collects N bit-slice beats of K coefficients and presents the reassembled
// coefficients on cdata0..3 with a one-cycle done pulse per completed frame.
module dcoef_collect
  import dcoef_collect_pkg::*;
#(
  parameter int N = DCOEF_N,
  parameter int K = DCOEF_K
) (
  input  logic            clk,
  input  logic            reset,
  dcoef_collect_if.slave  bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic          busy_q;
  logic [N-1:0]  cdata_q [K];
  logic [N-1:0]  cdata_d [K];
  logic [N-1:0]  shift_w [K];

  logic inCollect;
  logic lastBeat;
  logic sipoClr;
  logic sipoShift;

  assign inCollect = (state_q == COLLECT);
  assign lastBeat  = inCollect && bus.din_valid && (cnt_q == LAST_BEAT);

  // A start always clears; the final beat clears so the next frame begins empty.
  assign sipoClr   = bus.start || lastBeat;
  assign sipoShift = inCollect && bus.din_valid && !bus.start;

  for (genvar j = 0; j < K; j++) begin : g_lane
    dcoef_sipo #(.N(N)) u_sipo (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (sipoClr),
      .shift_i (sipoShift),
      .bit_i   (bus.dcoeff_in[j]),
      .q_o     (shift_w[j])
    );

    assign cdata_d[j] = (shift_w[j] >> 1) | (N'(bus.dcoeff_in[j]) << (N - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int j = 0; j < K; j++) begin
        cdata_q[j] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= COLLECT;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        COLLECT: begin
          // Completion wins over restart; a coincident start re-enters COLLECT.
          if (lastBeat) begin
            for (int j = 0; j < K; j++) begin
              cdata_q[j] <= cdata_d[j];
            end
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= bus.start ? COLLECT : IDLE;
            busy_q  <= bus.start;
          end else if (bus.start) begin
            cnt_q <= '0;
          end else if (bus.din_valid) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.cdata0 = cdata_q[0];
  assign bus.cdata1 = cdata_q[1];
  assign bus.cdata2 = cdata_q[2];
  assign bus.cdata3 = cdata_q[3];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_dcoef_collect.sv
// Self-checking bench for dcoef_collect: frame-level reference model compared
// every cycle, plus directed frames with hand-computed coefficient values.
module tb_dcoef_collect;

  localparam int N = 4;
  localparam int K = 4;

  logic clk;
  logic reset;
  int   nChecks;
  int   nFails;
  bit   checkEn;

  dcoef_collect_if #(.N(N), .K(K)) bus ();

  dcoef_collect #(.N(N), .K(K)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is just the list of accepted slices; coefficient
  // j is the word formed by bit j of each slice, first slice as bit 0.
  logic [K-1:0] beats [$];
  logic [N-1:0] mCdata [K];
  logic         mBusy;
  logic         mDone;

  function automatic logic [N-1:0] coefOf(int j);
    logic [N-1:0] r;
    logic [K-1:0] s;
    r = '0;
    for (int b = 0; b < N; b++) begin
      s    = beats[b];
      r[b] = s[j];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    mDone = 1'b0;
    if (!reset) begin
      mBusy = 1'b0;
      beats.delete();
      for (int j = 0; j < K; j++) mCdata[j] = '0;
    end else if (!mBusy) begin
      if (bus.start) begin
        mBusy = 1'b1;
        beats.delete();
      end
    end else if (bus.din_valid && beats.size() == N - 1) begin
      beats.push_back(bus.dcoeff_in);
      for (int j = 0; j < K; j++) mCdata[j] = coefOf(j);
      mDone = 1'b1;
      mBusy = bus.start;
      beats.delete();
    end else if (bus.start) begin
      beats.delete();
    end else if (bus.din_valid) begin
      beats.push_back(bus.dcoeff_in);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", 32'(bus.busy), 32'(mBusy));
      checkOutput("done", 32'(bus.done), 32'(mDone));
      checkOutput("cdata0", 32'(bus.cdata0), 32'(mCdata[0]));
      checkOutput("cdata1", 32'(bus.cdata1), 32'(mCdata[1]));
      checkOutput("cdata2", 32'(bus.cdata2), 32'(mCdata[2]));
      checkOutput("cdata3", 32'(bus.cdata3), 32'(mCdata[3]));
    end
  end

  task automatic applyStimulus(input logic s, input logic v, input logic [K-1:0] d);
    bus.start     = s;
    bus.din_valid = v;
    bus.dcoeff_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pinCdata(input string tag, input logic [N-1:0] c0, input logic [N-1:0] c1,
                          input logic [N-1:0] c2, input logic [N-1:0] c3);
    checkOutput({tag, ".c0"}, 32'(bus.cdata0), 32'(c0));
    checkOutput({tag, ".c1"}, 32'(bus.cdata1), 32'(c1));
    checkOutput({tag, ".c2"}, 32'(bus.cdata2), 32'(c2));
    checkOutput({tag, ".c3"}, 32'(bus.cdata3), 32'(c3));
  endtask

  task automatic frameA36F(input string tag);
    applyStimulus(1'b1, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 4'b0110);
    applyStimulus(1'b0, 1'b1, 4'b1111);
    applyStimulus(1'b0, 1'b1, 4'b1100);
    applyStimulus(1'b0, 1'b1, 4'b0101);
    checkOutput({tag, ".done"}, 32'(bus.done), 32'd1);
    pinCdata(tag, 4'hA, 4'h3, 4'hF, 4'h6);
  endtask

  initial begin
    nChecks       = 0;
    nFails        = 0;
    checkEn       = 1'b0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.din_valid = 1'b0;
    bus.dcoeff_in = '0;
    @(posedge clk);
    #1;
    checkEn = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0);
    checkOutput("reset.busy", 32'(bus.busy), 32'd0);
    checkOutput("reset.done", 32'(bus.done), 32'd0);
    pinCdata("reset", 4'h0, 4'h0, 4'h0, 4'h0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0);

    // Basic frame, then done must drop after one cycle.
    frameA36F("basic");
    checkOutput("basic.busy", 32'(bus.busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'h0);
    checkOutput("basic.donePulse", 32'(bus.done), 32'd0);

    // Same frame with a three-cycle stall between beats 2 and 3.
    applyStimulus(1'b1, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 4'b0110);
    applyStimulus(1'b0, 1'b1, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 4'($urandom));
      checkOutput("stall.busy", 32'(bus.busy), 32'd1);
    end
    applyStimulus(1'b0, 1'b1, 4'b1100);
    applyStimulus(1'b0, 1'b1, 4'b0101);
    checkOutput("stall.done", 32'(bus.done), 32'd1);
    pinCdata("stall", 4'hA, 4'h3, 4'hF, 4'h6);

    // Restart after two beats; coincident beat is discarded.
    applyStimulus(1'b1, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 4'b1010);
    applyStimulus(1'b0, 1'b1, 4'b1111);
    applyStimulus(1'b1, 1'b1, 4'b1111);
    checkOutput("restart.done", 32'(bus.done), 32'd0);
    applyStimulus(1'b0, 1'b1, 4'b0001);
    applyStimulus(1'b0, 1'b1, 4'b0010);
    applyStimulus(1'b0, 1'b1, 4'b0100);
    applyStimulus(1'b0, 1'b1, 4'b1000);
    checkOutput("restart.doneEnd", 32'(bus.done), 32'd1);
    pinCdata("restart", 4'h1, 4'h2, 4'h4, 4'h8);

    // Reset after three beats of a new frame; start/valid during reset ignored.
    frameA36F("preReset");
    applyStimulus(1'b1, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 4'b0011);
    applyStimulus(1'b0, 1'b1, 4'b0011);
    applyStimulus(1'b0, 1'b1, 4'b0011);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'b1111);
    reset = 1'b1;
    checkOutput("midReset.busy", 32'(bus.busy), 32'd0);
    checkOutput("midReset.done", 32'(bus.done), 32'd0);
    pinCdata("midReset", 4'h0, 4'h0, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 4'b1111);
    checkOutput("afterReset.busy", 32'(bus.busy), 32'd0);
    frameA36F("postReset");

    // Start coincident with the final beat chains straight into the next frame.
    applyStimulus(1'b1, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, 4'b0110);
    applyStimulus(1'b0, 1'b1, 4'b1111);
    applyStimulus(1'b0, 1'b1, 4'b1100);
    applyStimulus(1'b1, 1'b1, 4'b0101);
    checkOutput("chain.done", 32'(bus.done), 32'd1);
    checkOutput("chain.busy", 32'(bus.busy), 32'd1);
    pinCdata("chain1", 4'hA, 4'h3, 4'hF, 4'h6);
    applyStimulus(1'b0, 1'b1, 4'b0001);
    applyStimulus(1'b0, 1'b1, 4'b0010);
    applyStimulus(1'b0, 1'b1, 4'b0100);
    applyStimulus(1'b0, 1'b1, 4'b1000);
    checkOutput("chain2.done", 32'(bus.done), 32'd1);
    pinCdata("chain2", 4'h1, 4'h2, 4'h4, 4'h8);

    // din_valid in IDLE changes nothing.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 4'($urandom));
      checkOutput("idleValid.busy", 32'(bus.busy), 32'd0);
      checkOutput("idleValid.done", 32'(bus.done), 32'd0);
    end
    pinCdata("idleValid", 4'h1, 4'h2, 4'h4, 4'h8);

    // Randomized traffic checked by the reference model every cycle.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) != 0);
      applyStimulus(($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0), 4'($urandom));
    end
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 4'h0);

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
